// File: rtl/rotate_pipe.sv
// Pipelined barrel rotator/shifter, one registered stage per shift-amount bit, valid/ready on both sides.
// Optional completed-operation counter port ops_count is enabled by defining ROTATE_PIPE_STATS_EN.
module rotate_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ROTATE_PIPE_STATS_EN
  ,
  output logic [15:0]      ops_count
`endif
);

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSH = 2'b01;
  localparam logic [1:0] MODE_ASH = 2'b10;

  // Shift by k = 2^s when en is set; right arithmetic fills with the current MSB.
  function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d, input logic en,
                                                input logic dir, input logic [1:0] mode,
                                                input int k);
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (mode)
        MODE_ROT: r = dir ? ((d >> k) | (d << (WIDTH - k))) : ((d << k) | (d >> (WIDTH - k)));
        MODE_LSH: r = dir ? (d >> k) : (d << k);
        MODE_ASH: r = dir ? $unsigned($signed(d) >>> k) : (d << k);
        default:  r = d;
      endcase
    end
    return r;
  endfunction

  logic [SHW-1:0]   valid_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   dir_q;
  logic [1:0]       mode_q [SHW];

  logic [SHW-1:0]   up_valid;
  logic [WIDTH-1:0] up_data  [SHW];
  logic [SHW-1:0]   up_amt   [SHW];
  logic [SHW-1:0]   up_dir;
  logic [1:0]       up_mode  [SHW];
  logic [WIDTH-1:0] data_d   [SHW];
  logic [SHW-1:0]   load;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      if (gi == 0) begin : g_src_port
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = in_data;
        assign up_amt[gi]   = in_amt;
        assign up_dir[gi]   = in_dir;
        assign up_mode[gi]  = in_mode;
      end else begin : g_src_stage
        assign up_valid[gi] = valid_q[gi-1];
        assign up_data[gi]  = data_q[gi-1];
        assign up_amt[gi]   = amt_q[gi-1];
        assign up_dir[gi]   = dir_q[gi-1];
        assign up_mode[gi]  = mode_q[gi-1];
      end
      assign data_d[gi] = stage_fn(up_data[gi], up_amt[gi][gi], up_dir[gi], up_mode[gi], 1 << gi);
    end
  endgenerate

  // Load chain walks from the output back to the input so in_ready never depends on in_valid.
  always_comb begin
    logic adv;
    adv  = out_ready;
    load = '0;
    for (int s = SHW - 1; s >= 0; s--) begin
      load[s] = !valid_q[s] || adv;
      adv     = load[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dir_q   <= '0;
      for (int s = 0; s < SHW; s++) begin
        data_q[s] <= '0;
        amt_q[s]  <= '0;
        mode_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SHW; s++) begin
        if (load[s]) begin
          valid_q[s] <= up_valid[s];
          if (up_valid[s]) begin
            data_q[s] <= data_d[s];
            amt_q[s]  <= up_amt[s];
            dir_q[s]  <= up_dir[s];
            mode_q[s] <= up_mode[s];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];

`ifdef ROTATE_PIPE_STATS_EN
  logic [15:0] ops_count_q;
  logic [15:0] ops_count_d;

  always_comb begin
    ops_count_d = ops_count_q;
    if (out_valid && out_ready && (ops_count_q != 16'hFFFF)) begin
      ops_count_d = ops_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_count_q <= '0;
    end else begin
      ops_count_q <= ops_count_d;
    end
  end

  assign ops_count = ops_count_q;
`endif

endmodule

// File: tb/tb_rotate_pipe.sv
// Directed bench for rotate_pipe at WIDTH = 8: modes, latency, backpressure, reset and throughput.
// Counter checks are compiled in when ROTATE_PIPE_STATS_EN is defined.
module tb_rotate_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef ROTATE_PIPE_STATS_EN
  logic [15:0] ops_count;
`endif

  int checks   = 0;
  int failures = 0;

  rotate_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ROTATE_PIPE_STATS_EN
    ,
    .ops_count (ops_count)
`endif
  );

  always #5 clk = ~clk;

  // Drives one operand into an empty pipe and waits (bounded) for its result; lat counts the acceptance edge as 1.
  task automatic do_op(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] m,
                       output logic [7:0] res, output int lat, output logic rdy);
    in_data = d; in_amt = a; in_dir = dr; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef ROTATE_PIPE_STATS_EN
    checks++; if (ops_count !== 16'd0) begin failures++; $display("FAIL reset_ops_count got=%0d exp=0", ops_count); end
`endif
  endtask

  task automatic test_rotate();
    logic [7:0] r; int l; logic rd;
    do_op(8'b00011001, 3'd1, 1'b1, 2'b00, r, l, rd);
    checks++; if (r !== 8'b10001100) begin failures++; $display("FAIL rot_right_data got=%b exp=10001100", r); end
    checks++; if (l !== 3) begin failures++; $display("FAIL rot_right_latency got=%0d exp=3", l); end
    checks++; if (rd !== 1'b1) begin failures++; $display("FAIL rot_right_in_ready got=%b exp=1", rd); end
    do_op(8'b00011001, 3'd3, 1'b0, 2'b00, r, l, rd);
    checks++; if (r !== 8'b11001000) begin failures++; $display("FAIL rot_left_data got=%b exp=11001000", r); end
    checks++; if (l !== 3) begin failures++; $display("FAIL rot_left_latency got=%0d exp=3", l); end
  endtask

  task automatic test_shift();
    logic [7:0] r; int l; logic rd;
    do_op(8'b10010000, 3'd2, 1'b1, 2'b10, r, l, rd);
    checks++; if (r !== 8'b11100100) begin failures++; $display("FAIL ash_right_data got=%b exp=11100100", r); end
    do_op(8'b10010000, 3'd2, 1'b1, 2'b01, r, l, rd);
    checks++; if (r !== 8'b00100100) begin failures++; $display("FAIL lsh_right_data got=%b exp=00100100", r); end
    do_op(8'b00011001, 3'd5, 1'b0, 2'b01, r, l, rd);
    checks++; if (r !== 8'b00100000) begin failures++; $display("FAIL lsh_left_data got=%b exp=00100000", r); end
    do_op(8'b10010011, 3'd3, 1'b0, 2'b10, r, l, rd);
    checks++; if (r !== 8'b10011000) begin failures++; $display("FAIL ash_left_data got=%b exp=10011000", r); end
  endtask

  task automatic test_pass();
    logic [7:0] r; int l; logic rd;
    do_op(8'b10100101, 3'd7, 1'b1, 2'b11, r, l, rd);
    checks++; if (r !== 8'b10100101) begin failures++; $display("FAIL pass_mode_data got=%b exp=10100101", r); end
    do_op(8'b11110000, 3'd0, 1'b0, 2'b00, r, l, rd);
    checks++; if (r !== 8'b11110000) begin failures++; $display("FAIL amt0_data got=%b exp=11110000", r); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drained_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ops [5];
    logic [7:0] exp [5];
    logic [7:0] held;
    logic held_ok, seen;
    int acc, got;
    ops = '{8'h01, 8'h02, 8'h03, 8'h80, 8'h55};
    exp = '{8'h02, 8'h04, 8'h06, 8'h01, 8'hAA};
    acc = 0; got = 0; held = '0; held_ok = 1'b1; seen = 1'b0;
    in_amt = 3'd1; in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) in_data = ops[acc];
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin held = out_data; seen = 1'b1; end
        else if (out_data !== held) held_ok = 1'b0;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    checks++; if (acc !== 3) begin failures++; $display("FAIL bp_accepts got=%0d exp=3", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    checks++; if (!(seen && held_ok && held === 8'h02)) begin
      failures++; $display("FAIL bp_stall_stable got=seen%b/stable%b/%h exp=seen1/stable1/02", seen, held_ok, held);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_recover got=%b exp=1", in_ready); end
    for (int c = 0; c < 30 && got < 5; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) in_data = ops[acc];
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp[got]) begin failures++; $display("FAIL bp_result%0d got=%h exp=%h", got, out_data, exp[got]); end
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (got !== 5 || acc !== 5) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=5/5", got, acc); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    out_ready = 1'b1; in_mode = 2'b11; in_amt = 3'd0; in_dir = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_data = 8'h22;
    @(posedge clk); #1;
    rst = 1'b1; in_data = 8'h33;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
`ifdef ROTATE_PIPE_STATS_EN
    checks++; if (ops_count !== 16'd0) begin failures++; $display("FAIL rstmid_ops_count got=%0d exp=0", ops_count); end
`endif
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    @(posedge clk); #1;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_ghost_results got=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    int acc, got, first, gaps;
    acc = 0; got = 0; first = -1; gaps = 0;
    in_mode = 2'b00; in_dir = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 20; c++) begin
      in_valid = (acc < 20);
      if (acc < 20) begin in_data = 8'h01; in_amt = 3'(acc % 8); end
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        exp_v = 8'h01 << ((8 - (got % 8)) % 8);
        checks++;
        if (out_data !== exp_v) begin failures++; $display("FAIL b2b_result%0d got=%h exp=%h", got, out_data, exp_v); end
        got++;
      end else if (first >= 0) begin
        gaps++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (first !== 3) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=3", first); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
    checks++; if (got !== 20) begin failures++; $display("FAIL b2b_results got=%0d exp=20", got); end
`ifdef ROTATE_PIPE_STATS_EN
    checks++; if (ops_count !== 16'd20) begin failures++; $display("FAIL b2b_ops_count got=%0d exp=20", ops_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift();
    test_pass();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_pipe.md
# rotate_pipe

Parametrised, pipelined barrel rotator/shifter with valid/ready handshakes on both sides. It generalises the team's fixed 8-bit combinational rotator in three ways:
- arbitrary power-of-two width;
- rotate, logical-shift and arithmetic-shift modes;
- one registered stage per shift-amount bit.

It sits in the datapath between an operand producer and a result consumer. It sustains one operation per cycle under full throughput.

## Interface
- WIDTH, 8, data width; power of two, 2..64
- SHW, $clog2(WIDTH), shift-amount width and number of pipeline stages (derived, do not override)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  block accepts operand this cycle
- in_data  input  WIDTH  operand
- in_amt  input  SHW  shift/rotate amount, 0..WIDTH-1
- in_dir  input  1  1 = right, 0 = left
- in_mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 pass-through
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- ops_count  output  16  completed-operation counter (only with ROTATE_PIPE_STATS_EN)

## Operation
- **Transfers.** An operand transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- **Stage registers.** Stage s (s = 0..SHW-1) holds:
  - valid_s, data_s;
  - the remaining amt/dir/mode bits.
- **Stage function.** Stage s applies a shift of 2^s when amt[s] = 1, else passes data unchanged.
- **Rotate right by k.** out[i] = in[(i+k) mod WIDTH].
- **Rotate left by k.** out[i] = in[(i-k+WIDTH) mod WIDTH].
- **Logical shift.** Vacated bits fill with 0, either direction.
- **Arithmetic shift right.** Vacated bits fill with the current MSB of data_s. Applied per stage, this reproduces the original sign.
- **Arithmetic shift left.** Identical to logical left.
- **Mode 11.** Data passes unchanged regardless of amt and dir.
- **Amount 0.** Output equals input in every mode.
- **Advance rule.** Stage s loads from stage s-1 (stage 0 loads from the input port) when valid_s = 0 or stage s is advancing.
  - Stage SHW-1 advances when out_ready = 1.
  - Stage s < SHW-1 advances when stage s+1 loads.
  - If a stage is empty, its downstream advances and its upstream is invalid, the stage clears valid_s.
- **Input ready.** in_ready = stage 0 loads. This is combinational from out_ready through the stage valids; there is no combinational path from in_valid to in_ready.
- **Outputs.** out_valid = valid_(SHW-1). out_data = data_(SHW-1).
- **Ordering.** Results leave in acceptance order. No operation is dropped or duplicated.
- **Reset.** rst = 1 clears:
  - all valid_s and data_s;
  - ops_count.

## Timing
- **Reset values.**
  - out_valid = 0, out_data = 0, ops_count = 0.
  - in_ready = 1 from the first cycle after reset.
- **Latency.** Exactly SHW cycles: an operand accepted at edge k appears with out_valid = 1 after edge k+SHW-1 (WIDTH = 8: third cycle after acceptance).
- **Throughput.** One operation per cycle while out_ready = 1.
- **Full pipeline with out_ready = 1.** The pipeline accepts a new operand and emits a result in the same cycle.
- **Backpressure.** With out_ready = 0:
  - out_data and out_valid hold stable;
  - the pipeline fills up to SHW entries, then in_ready = 0.
  - in_ready recovers combinationally in the cycle out_ready rises.
- **Reset mid-operation.** In-flight operations are discarded. out_valid = 0 in the cycle after the reset edge. An operand presented during rst = 1 is not accepted.
- **in_amt ≥ WIDTH.** Not encodable: SHW bits cover 0..WIDTH-1 exactly.

## Configuration
- **ROTATE_PIPE_STATS_EN defined.**
  - ops_count port exists.
  - It increments by 1 on each result transfer.
  - It saturates at 16'hFFFF and clears on rst.
- **ROTATE_PIPE_STATS_EN undefined.** The port and counter logic are absent. Datapath and handshake behaviour are identical to the defined case.

## Test plan
All scenarios use WIDTH = 8.
- **Rotate right / rotate left.**
  - Rotate right, amt 1, data 00011001 -> 10001100, out_valid 3 cycles after acceptance.
  - Rotate left, amt 3, data 00011001 -> 11001000.
- **Shift modes.**
  - Arithmetic right, amt 2, data 10010000 -> 11100100.
  - Logical right, amt 2, data 10010000 -> 00100100.
  - Logical left, amt 5, data 00011001 -> 00100000.
- **Pass-through and amount 0.**
  - Mode 11, amt 7, data 10100101 -> 10100101.
  - Rotate, amt 0, data 11110000 -> 11110000.
- **Backpressure.**
  - Stimulus: stream 5 operands with in_valid held; out_ready = 0 for 6 cycles, then 1.
  - in_ready drops after 3 accepts.
  - All 5 results emerge in order with no loss; out_data is stable while stalled.
- **Reset mid-operation.**
  - Stimulus: accept 2 operands, assert rst for 1 cycle before either completes.
  - No result appears, out_valid = 0, in_ready = 1 afterwards.
  - With ROTATE_PIPE_STATS_EN, ops_count = 0.
- **Full throughput.**
  - Stimulus: 20 back-to-back operations with out_ready = 1.
  - One result per cycle from cycle 3 on.
  - With ROTATE_PIPE_STATS_EN, ops_count = 20 at end.
